// File: rtl/fabric_config_loader.sv
// Frame-based configuration loader: parses a sync/header/data word stream and
// writes one row-data frame into the fabric with a single one-hot strobe pulse.
module fabric_config_loader #(
    parameter int unsigned NumberOfRows    = 4,
    parameter int unsigned NumberOfCols    = 4,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramePerCol  = 32,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
    input  logic                                      UserCLK,
    input  logic                                      resetn,
    input  logic [31:0]                               s_data,
    input  logic                                      s_valid,
    output logic                                      s_ready,
    output logic [FrameBitsPerRow*NumberOfRows-1:0]   FrameData,
    output logic [MaxFramePerCol*NumberOfCols-1:0]    FrameStrobe,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      error
);

    localparam int unsigned RowW    = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam int unsigned ColW    = (NumberOfCols > 1) ? $clog2(NumberOfCols) : 1;
    localparam int unsigned FrameW  = (MaxFramePerCol > 1) ? $clog2(MaxFramePerCol) : 1;
    localparam int unsigned StrobeW = MaxFramePerCol * NumberOfCols;
    localparam logic [7:0]  CmdWrite = 8'h01;
    localparam logic [7:0]  CmdEnd   = 8'h02;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        DATA   = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [RowW-1:0]     row_cnt;
    logic [ColW-1:0]     col_q;
    logic [FrameW-1:0]   frame_q;

    logic                accept;
    logic [7:0]          hdr_cmd, hdr_col, hdr_frame;
    logic                col_ok, frame_ok;
    logic                hdr_ld, data_ld;
    logic                ready_d, busy_d, done_d, error_d;
    logic [StrobeW-1:0]  strobe_d;

    assign accept    = s_valid && s_ready;
    assign hdr_cmd   = s_data[31:24];
    assign hdr_col   = s_data[23:16];
    assign hdr_frame = s_data[15:8];
    assign col_ok    = 32'(hdr_col) < NumberOfCols;
    assign frame_ok  = 32'(hdr_frame) < MaxFramePerCol;

    // Next state, next registered outputs and datapath load enables
    always_comb begin
        state_d  = state_q;
        done_d   = done;
        error_d  = error;
        hdr_ld   = 1'b0;
        data_ld  = 1'b0;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        strobe_d = '0;

        case (state_q)
            IDLE: begin
                if (accept && (s_data == SyncWord)) begin
                    state_d = HEADER;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end
            HEADER: begin
                if (accept) begin
                    if ((hdr_cmd == CmdWrite) && col_ok && frame_ok) begin
                        hdr_ld  = 1'b1;
                        state_d = DATA;
                    end else if (hdr_cmd == CmdEnd) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    data_ld = 1'b1;
                    if (row_cnt == RowW'(NumberOfRows - 1)) begin
                        state_d = STROBE;
                    end
                end
            end
            STROBE:  state_d = HOLD;
            HOLD:    state_d = HEADER;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE) || (state_d == HEADER) || (state_d == DATA);
        busy_d  = (state_d != IDLE);

        // Decode the latched target into the registered one-hot strobe
        for (int c = 0; c < int'(NumberOfCols); c++) begin
            for (int f = 0; f < int'(MaxFramePerCol); f++) begin
                strobe_d[c*int'(MaxFramePerCol) + f] = (state_d == STROBE) &&
                    (col_q == ColW'(c)) && (frame_q == FrameW'(f));
            end
        end
    end

    // State and registered outputs; reset clears the strobe immediately
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            FrameStrobe <= '0;
        end else begin
            state_q     <= state_d;
            s_ready     <= ready_d;
            busy        <= busy_d;
            done        <= done_d;
            error       <= error_d;
            FrameStrobe <= strobe_d;
        end
    end

    // Frame target, row counter and row data; data only moves on accepted DATA words
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            col_q     <= '0;
            frame_q   <= '0;
            row_cnt   <= '0;
            FrameData <= '0;
        end else begin
            if (hdr_ld) begin
                col_q   <= ColW'(hdr_col);
                frame_q <= FrameW'(hdr_frame);
                row_cnt <= '0;
            end else if (data_ld && (row_cnt != RowW'(NumberOfRows - 1))) begin
                row_cnt <= row_cnt + RowW'(1);
            end
            for (int r = 0; r < int'(NumberOfRows); r++) begin
                if (data_ld && (row_cnt == RowW'(r))) begin
                    FrameData[r*int'(FrameBitsPerRow) +: FrameBitsPerRow] <= FrameBitsPerRow'(s_data);
                end
            end
        end
    end

endmodule

// File: tb/tb_fabric_config_loader.sv
// Self-checking bench for fabric_config_loader: directed vector table, timing
// sequences, and a randomized word stream checked against a stream-parsing model.
module tb_fabric_config_loader;

    localparam int NROWS = 4;
    localparam int NCOLS = 4;
    localparam int MAXF  = 32;
    localparam int SW    = NCOLS * MAXF;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic            UserCLK = 1'b0;
    logic            resetn  = 1'b0;
    logic [31:0]     s_data  = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [127:0]    FrameData;
    logic [SW-1:0]   FrameStrobe;
    logic            busy, done, error;

    fabric_config_loader dut (
        .UserCLK     (UserCLK),
        .resetn      (resetn),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 UserCLK = ~UserCLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int obs_base = 0;
    logic [31:0]  sent_q[$];
    int           obs_idx[$];
    int           obs_ones[$];
    int           obs_cyc[$];
    logic [127:0] obs_data[$];
    int           exp_idx_q[$];
    logic [127:0] exp_data_q[$];

    always @(posedge UserCLK) cyc <= cyc + 1;

    // Record every cycle in which any strobe bit is high
    always @(negedge UserCLK) begin
        if (resetn && (FrameStrobe != '0)) begin
            int first;
            first = -1;
            for (int i = 0; i < SW; i++) if (FrameStrobe[i] && first < 0) first = i;
            obs_idx.push_back(first);
            obs_ones.push_back($countones(FrameStrobe));
            obs_data.push_back(FrameData);
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge UserCLK); #1;
        resetn  = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("rst_ready", 128'(s_ready), 128'(0));
        chk("rst_strobe", FrameStrobe, '0);
        chk("rst_data", FrameData, '0);
        chk("rst_flags", 128'({busy, done, error}), 128'(0));
        sent_q.delete();
        obs_base = obs_idx.size();
        @(negedge UserCLK);
        resetn = 1'b1;
        @(posedge UserCLK); #1;
        chk("rst_ready_after", 128'(s_ready), 128'(1));
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        int n;
        n = 0;
        s_valid = 1'b0;
        repeat (gap) begin @(posedge UserCLK); #1; end
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && n < 40) begin @(posedge UserCLK); #1; n++; end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready stayed %0b for word %08h", s_ready, w);
            s_valid = 1'b0;
        end else begin
            @(posedge UserCLK); #1;
            s_valid = 1'b0;
            sent_q.push_back(w);
        end
    endtask

    task automatic send_frame(input logic [31:0] hdr, input logic [127:0] d, input int gap);
        send(hdr, gap);
        for (int r = 0; r < NROWS; r++) send(d[32*r +: 32], gap);
    endtask

    // Reference: parse the accepted word stream by the protocol rules
    task automatic run_model(output bit m_done, output bit m_err);
        int mode, rows, idx;
        logic [127:0] fd;
        logic [31:0] w;
        mode = 0; rows = 0; idx = 0; fd = '0;
        m_done = 1'b0; m_err = 1'b0;
        exp_idx_q.delete();
        exp_data_q.delete();
        foreach (sent_q[i]) begin
            w = sent_q[i];
            if (mode == 0) begin
                if (w == SYNC) begin mode = 1; m_done = 1'b0; m_err = 1'b0; end
            end else if (mode == 1) begin
                if (w[31:24] == 8'h01 && int'(w[23:16]) < NCOLS && int'(w[15:8]) < MAXF) begin
                    idx = int'(w[23:16]) * MAXF + int'(w[15:8]);
                    rows = 0;
                    mode = 2;
                end else begin
                    if (w[31:24] == 8'h02) m_done = 1'b1;
                    else m_err = 1'b1;
                    mode = 0;
                end
            end else begin
                fd[32*rows +: 32] = w;
                rows++;
                if (rows == NROWS) begin
                    exp_idx_q.push_back(idx);
                    exp_data_q.push_back(fd);
                    mode = 1;
                end
            end
        end
    endtask

    task automatic check_stream(input string name);
        bit m_done, m_err;
        int n_obs, n;
        run_model(m_done, m_err);
        n_obs = obs_idx.size() - obs_base;
        chk($sformatf("%s_count", name), 128'(n_obs), 128'(exp_idx_q.size()));
        n = (n_obs < exp_idx_q.size()) ? n_obs : exp_idx_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_idx%0d", name, i), 128'(obs_idx[obs_base+i]), 128'(exp_idx_q[i]));
            chk($sformatf("%s_onehot%0d", name, i), 128'(obs_ones[obs_base+i]), 128'(1));
            chk($sformatf("%s_data%0d", name, i), obs_data[obs_base+i], exp_data_q[i]);
        end
        chk($sformatf("%s_done", name), 128'(done), 128'(m_done));
        chk($sformatf("%s_error", name), 128'(error), 128'(m_err));
    endtask

    typedef struct {
        logic [31:0]  hdr;
        logic [127:0] data;
        int           n_strobe;
        int           idx;
        bit           exp_err;
        bit           exp_done;
    } vec_t;

    initial begin
        vec_t vecs[9];
        logic [127:0] e;
        logic [127:0] d;
        logic [127:0] plan_d;
        int r, gap;

        plan_d = 128'h44444444_33333333_22222222_11111111;
        vecs[0] = '{32'h01020500, plan_d, 1, 69, 1'b0, 1'b0};
        vecs[1] = '{32'h01000000, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 1, 0, 1'b0, 1'b0};
        vecs[2] = '{32'h01031FAB, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 1, 127, 1'b0, 1'b0};
        vecs[3] = '{32'h01011000, 128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0, 1, 48, 1'b0, 1'b0};
        vecs[4] = '{32'h01040000, '0, 0, 0, 1'b1, 1'b0};
        vecs[5] = '{32'h01002000, '0, 0, 0, 1'b1, 1'b0};
        vecs[6] = '{32'h05000000, '0, 0, 0, 1'b1, 1'b0};
        vecs[7] = '{32'h02000000, '0, 0, 0, 1'b0, 1'b1};
        vecs[8] = '{32'h02FFFF00, '0, 0, 0, 1'b0, 1'b1};

        for (int v = 0; v < 9; v++) begin
            do_reset();
            send(SYNC, 0);
            send(vecs[v].hdr, 0);
            if (vecs[v].n_strobe != 0)
                for (int k = 0; k < NROWS; k++) send(vecs[v].data[32*k +: 32], 0);
            repeat (3) @(negedge UserCLK);
            chk($sformatf("vec%0d_count", v), 128'(obs_idx.size() - obs_base), 128'(vecs[v].n_strobe));
            if (vecs[v].n_strobe != 0 && obs_idx.size() > obs_base) begin
                chk($sformatf("vec%0d_idx", v), 128'(obs_idx[obs_base]), 128'(vecs[v].idx));
                chk($sformatf("vec%0d_data", v), obs_data[obs_base], vecs[v].data);
            end
            chk($sformatf("vec%0d_error", v), 128'(error), 128'(vecs[v].exp_err));
            chk($sformatf("vec%0d_done", v), 128'(done), 128'(vecs[v].exp_done));
        end

        // Strobe timing relative to the last data word
        do_reset();
        send(SYNC, 0);
        send_frame(32'h01020500, plan_d, 0);
        e = '0;
        e[69] = 1'b1;
        @(negedge UserCLK);
        chk("plan_strobe_hi", FrameStrobe, e);
        chk("plan_ready_lo1", 128'(s_ready), 128'(0));
        chk("plan_data", FrameData, plan_d);
        @(negedge UserCLK);
        chk("plan_strobe_lo", FrameStrobe, '0);
        chk("plan_ready_lo2", 128'(s_ready), 128'(0));
        chk("plan_data_hold", FrameData, plan_d);
        @(negedge UserCLK);
        chk("plan_ready_hi", 128'(s_ready), 128'(1));
        chk("plan_busy", 128'(busy), 128'(1));
        check_stream("plan");

        // s_valid toggled every other cycle
        do_reset();
        send(SYNC, 1);
        send_frame(32'h01020500, plan_d, 1);
        repeat (3) @(negedge UserCLK);
        chk("gap_data", FrameData, plan_d);
        check_stream("gap");

        // Garbage before sync is discarded
        do_reset();
        send(32'hDEADBEEF, 0);
        send(32'h01000000, 0);
        @(negedge UserCLK);
        chk("garbage_busy", 128'(busy), 128'(0));
        send(SYNC, 0);
        send_frame(32'h01020500, plan_d, 0);
        repeat (3) @(negedge UserCLK);
        check_stream("garbage");

        // Out-of-range column sets error; next sync clears it
        do_reset();
        send(SYNC, 0);
        send(32'h01040000, 0);
        @(negedge UserCLK);
        chk("err_set", 128'(error), 128'(1));
        chk("err_idle", 128'(busy), 128'(0));
        send(SYNC, 0);
        @(negedge UserCLK);
        chk("err_clear", 128'(error), 128'(0));
        chk("err_busy", 128'(busy), 128'(1));
        check_stream("err");

        // Back-to-back frames at minimum period, then end
        do_reset();
        send(SYNC, 0);
        send_frame(32'h01000000, 128'h1, 0);
        send_frame(32'h01031F00, 128'h2, 0);
        send(32'h02000000, 0);
        repeat (3) @(negedge UserCLK);
        check_stream("b2b");
        if (obs_idx.size() - obs_base == 2)
            chk("b2b_spacing", 128'(obs_cyc[obs_base+1] - obs_cyc[obs_base]), 128'(7));
        else
            chk("b2b_pulses", 128'(obs_idx.size() - obs_base), 128'(2));

        // Reset in the middle of DATA, then a clean frame
        do_reset();
        send(SYNC, 0);
        send(32'h01020500, 0);
        send(32'hAAAAAAAA, 0);
        send(32'hBBBBBBBB, 0);
        do_reset();
        d = 128'h89898989_67676767_45454545_23232323;
        send(SYNC, 0);
        send_frame(32'h01010300, d, 0);
        repeat (3) @(negedge UserCLK);
        chk("midrst_data", FrameData, d);
        chk("midrst_idx", 128'(obs_idx.size() > obs_base ? obs_idx[obs_base] : -1), 128'(35));
        check_stream("midrst");

        // Randomized token stream with random valid gaps
        do_reset();
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            d = {$urandom, $urandom, $urandom, $urandom};
            if (r <= 4) begin
                send(SYNC, gap);
                send_frame({8'h01, 8'($urandom_range(0, NCOLS-1)), 8'($urandom_range(0, MAXF-1)), 8'($urandom)}, d, gap);
            end else if (r == 5) begin
                send($urandom, gap);
            end else if (r == 6) begin
                send({8'h01, 8'($urandom_range(NCOLS, 255)), 8'($urandom), 8'($urandom)}, gap);
            end else if (r == 7) begin
                send(32'h02000000, gap);
            end else if (r == 8) begin
                send(SYNC, gap);
            end else begin
                send_frame({8'h01, 8'($urandom_range(0, NCOLS-1)), 8'($urandom_range(0, MAXF-1)), 8'h00}, d, gap);
            end
        end
        repeat (4) @(negedge UserCLK);
        check_stream("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
